// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state codes, result_src codes, control bundle.
// Pure definitions, no latency.
// No backpressure; the constants are consumed by the decoder, the pipeline registers and the sequencer.
package pipe_hazard_ctl_pkg;

    // Sequencer states; the encoding is visible on the debug port, so keep it stable.
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_TRAP_DRAIN = 2'd2,
        ST_TRAP_REDIR = 2'd3
    } state_t;

    // result_src codes shared with the decoder and the writeback mux.
    localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;
    localparam logic [1:0] RESULT_SRC_CSR  = 2'b11;

    // Drain counter width covers trap drain lengths of 1..7 cycles.
    localparam int DRAIN_CNT_W = 3;

    // One bundle for every per-cycle control the sequencer drives.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic ex_mem_flush;
        logic trap_redirect;
    } ctl_t;

    // Free-running pipeline: everything advances, nothing is squashed.
    localparam ctl_t CTL_NORMAL = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
        id_ex_en: 1'b1, id_ex_flush: 1'b0,
        ex_mem_en: 1'b1, ex_mem_flush: 1'b0,
        trap_redirect: 1'b0
    };

    // Data memory busy: every stage register holds.
    localparam ctl_t CTL_FREEZE = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
        id_ex_en: 1'b0, id_ex_flush: 1'b0,
        ex_mem_en: 1'b0, ex_mem_flush: 1'b0,
        trap_redirect: 1'b0
    };

    // Taken branch/jump: squash the two younger instructions, fetch keeps going.
    localparam ctl_t CTL_BRANCH = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
        id_ex_en: 1'b1, id_ex_flush: 1'b1,
        ex_mem_en: 1'b1, ex_mem_flush: 1'b0,
        trap_redirect: 1'b0
    };

    // Load-use: hold PC and IF_ID for one cycle and inject a bubble into EX.
    localparam ctl_t CTL_LOAD_USE = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
        id_ex_en: 1'b1, id_ex_flush: 1'b1,
        ex_mem_en: 1'b1, ex_mem_flush: 1'b0,
        trap_redirect: 1'b0
    };

    // Trap entry and drain: PC frozen, all younger work squashed.
    localparam ctl_t CTL_DRAIN = '{
        pc_en: 1'b0, if_id_en: 1'b1, if_id_flush: 1'b1,
        id_ex_en: 1'b1, id_ex_flush: 1'b1,
        ex_mem_en: 1'b1, ex_mem_flush: 1'b1,
        trap_redirect: 1'b0
    };

    // Redirect cycle: PC loads the trap/return target, the stale fetch is dropped.
    localparam ctl_t CTL_REDIR = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
        id_ex_en: 1'b1, id_ex_flush: 1'b0,
        ex_mem_en: 1'b1, ex_mem_flush: 1'b0,
        trap_redirect: 1'b1
    };

    // True when a load in EX produces a register that the instruction in ID reads.
    function automatic logic load_use_hit(
        input logic       reg_wr_e,
        input logic [1:0] result_src_e,
        input logic [1:0] load_src,
        input logic [4:0] rd_e,
        input logic [4:0] rs1_d,
        input logic [4:0] rs2_d
    );
        return reg_wr_e && (result_src_e == load_src) && (rd_e != 5'd0) &&
               ((rd_e == rs1_d) || (rd_e == rs2_d));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctl_sat_counter32.sv
// Saturating 32-bit event counter for performance monitoring.
// Count visible one cycle after the increment request.
// No backpressure; holds at all-ones instead of wrapping.
module sat_counter32 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inc,
    output logic [31:0] o_count
);

    logic [31:0] count_q;

    // Count requested cycles, sticking at the maximum value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= 32'd0;
        end else if (i_inc && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard sequencer: stage enables/flushes for load-use, branch, memory wait and trap drain/redirect.
// Controls are combinational from the registered state and current inputs (zero latency); state updates on posedge.
// Memory busy freezes all four stage registers until the cycle it drops, which is handled as a normal RUN cycle.
module pipe_hazard_ctl
    import pipe_hazard_ctl_pkg::*;
#(
    parameter logic [1:0] LOAD_SRC   = RESULT_SRC_LOAD,
    parameter int         TRAP_DRAIN = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_rs1_d,
    input  logic [4:0]  i_rs2_d,
    input  logic [4:0]  i_rd_e,
    input  logic        i_reg_wr_e,
    input  logic [1:0]  i_result_src_e,
    input  logic        i_pc_src_e,
    input  logic        i_exception_m,
    input  logic        i_mret_m,
    input  logic        i_mem_busy,
    output logic        o_pc_clk_en,
    output logic        o_if_id_clk_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_clk_en,
    output logic        o_id_ex_flush,
    output logic        o_ex_mem_clk_en,
    output logic        o_ex_mem_flush,
    output logic        o_trap_redirect,
    output logic        o_trap_is_mret,
    output logic [1:0]  o_state,
    output logic [31:0] o_stall_cycles
);

    // Drain counter starts one below the drain length and counts down to zero.
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(TRAP_DRAIN - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [DRAIN_CNT_W-1:0] cnt;
    logic [DRAIN_CNT_W-1:0] cnt_nxt;
    logic                   trap_is_mret;
    logic                   trap_is_mret_nxt;

    logic trap_req;
    logic load_use;
    logic run_cycle;
    logic take_trap;
    ctl_t run_ctl;
    ctl_t ctl;

    assign trap_req = i_exception_m | i_mret_m;
    assign load_use = load_use_hit(i_reg_wr_e, i_result_src_e, LOAD_SRC,
                                   i_rd_e, i_rs1_d, i_rs2_d);

    // A cycle is evaluated with the full RUN priority list in RUN, and in MEM_WAIT once memory frees up.
    assign run_cycle = (state == ST_RUN) || ((state == ST_MEM_WAIT) && !i_mem_busy);
    assign take_trap = run_cycle && trap_req;

    // RUN priority: trap > memory busy > taken branch > load-use > free run.
    always_comb begin
        run_ctl = CTL_NORMAL;
        if (trap_req) begin
            run_ctl = CTL_DRAIN;
        end else if (i_mem_busy) begin
            run_ctl = CTL_FREEZE;
        end else if (i_pc_src_e) begin
            run_ctl = CTL_BRANCH;
        end else if (load_use) begin
            run_ctl = CTL_LOAD_USE;
        end
    end

    // State, drain counter and trap-kind register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_RUN;
            cnt          <= '0;
            trap_is_mret <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            trap_is_mret <= trap_is_mret_nxt;
        end
    end

    // Next-state selection; exceptions and busy are ignored while a trap is draining.
    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        trap_is_mret_nxt = trap_is_mret;
        unique case (state)
            ST_RUN: begin
                if (trap_req) begin
                    state_nxt = ST_TRAP_DRAIN;
                end else if (i_mem_busy) begin
                    state_nxt = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (i_mem_busy) begin
                    state_nxt = ST_MEM_WAIT;
                end else if (trap_req) begin
                    state_nxt = ST_TRAP_DRAIN;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_TRAP_DRAIN: begin
                if (cnt == '0) begin
                    state_nxt = ST_TRAP_REDIR;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_TRAP_REDIR: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
        // An exception in the same cycle as mret wins, so the redirect goes to mtvec.
        if (take_trap) begin
            cnt_nxt          = DRAIN_INIT;
            trap_is_mret_nxt = i_mret_m & ~i_exception_m;
        end
    end

    // Per-state stage controls; reset forces the free-running pattern with no redirect.
    always_comb begin
        ctl = CTL_NORMAL;
        unique case (state)
            ST_RUN:        ctl = run_ctl;
            ST_MEM_WAIT:   ctl = i_mem_busy ? CTL_FREEZE : run_ctl;
            ST_TRAP_DRAIN: ctl = CTL_DRAIN;
            ST_TRAP_REDIR: ctl = CTL_REDIR;
            default:       ctl = CTL_NORMAL;
        endcase
        if (i_rst) begin
            ctl = CTL_NORMAL;
        end
    end

    assign o_pc_clk_en     = ctl.pc_en;
    assign o_if_id_clk_en  = ctl.if_id_en;
    assign o_if_id_flush   = ctl.if_id_flush;
    assign o_id_ex_clk_en  = ctl.id_ex_en;
    assign o_id_ex_flush   = ctl.id_ex_flush;
    assign o_ex_mem_clk_en = ctl.ex_mem_en;
    assign o_ex_mem_flush  = ctl.ex_mem_flush;
    assign o_trap_redirect = ctl.trap_redirect;
    assign o_trap_is_mret  = trap_is_mret;
    assign o_state         = state;

    sat_counter32 u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (~ctl.pc_en),
        .o_count (o_stall_cycles)
    );

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl with a queue-based scoreboard.
// Driver applies one vector per cycle after posedge and queues the expected outputs.
// Monitor pops and compares on the following negedge.
module tb_pipe_hazard_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rd_e;
    logic        reg_wr_e;
    logic [1:0]  result_src_e;
    logic        pc_src_e, exception_m, mret_m, mem_busy;
    logic        pc_clk_en, if_id_clk_en, if_id_flush, id_ex_clk_en, id_ex_flush;
    logic        ex_mem_clk_en, ex_mem_flush, trap_redirect, trap_is_mret;
    logic [1:0]  state;
    logic [31:0] stall_cycles;

    // ctl bits: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, redirect}
    localparam logic [7:0] NRM = 8'b1101_0100;
    localparam logic [7:0] LU  = 8'b0001_1100;
    localparam logic [7:0] BR  = 8'b1111_1100;
    localparam logic [7:0] FRZ = 8'b0000_0000;
    localparam logic [7:0] TRP = 8'b0111_1110;
    localparam logic [7:0] RDR = 8'b1111_0101;

    typedef struct packed {
        logic [7:0]  ctl;
        logic        mret;
        logic [1:0]  st;
        logic [31:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_no = 0;

    pipe_hazard_ctl #(.LOAD_SRC(2'b01), .TRAP_DRAIN(2)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_rs1_d         (rs1_d),
        .i_rs2_d         (rs2_d),
        .i_rd_e          (rd_e),
        .i_reg_wr_e      (reg_wr_e),
        .i_result_src_e  (result_src_e),
        .i_pc_src_e      (pc_src_e),
        .i_exception_m   (exception_m),
        .i_mret_m        (mret_m),
        .i_mem_busy      (mem_busy),
        .o_pc_clk_en     (pc_clk_en),
        .o_if_id_clk_en  (if_id_clk_en),
        .o_if_id_flush   (if_id_flush),
        .o_id_ex_clk_en  (id_ex_clk_en),
        .o_id_ex_flush   (id_ex_flush),
        .o_ex_mem_clk_en (ex_mem_clk_en),
        .o_ex_mem_flush  (ex_mem_flush),
        .o_trap_redirect (trap_redirect),
        .o_trap_is_mret  (trap_is_mret),
        .o_state         (state),
        .o_stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input logic wr, input logic [1:0] src,
                          input logic br, input logic exc, input logic mr, input logic busy);
        rst = r; rs1_d = s1; rs2_d = s2; rd_e = d; reg_wr_e = wr;
        result_src_e = src; pc_src_e = br; exception_m = exc; mret_m = mr; mem_busy = busy;
    endtask

    // One cycle: apply inputs after posedge and queue the outputs expected during that cycle.
    task automatic step(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic wr, input logic [1:0] src,
                        input logic br, input logic exc, input logic mr, input logic busy,
                        input logic [7:0] e_ctl, input logic e_mret, input logic [1:0] e_st,
                        input logic [31:0] e_stall);
        exp_t e;
        @(posedge clk);
        #1;
        set_in(r, s1, s2, d, wr, src, br, exc, mr, busy);
        e.ctl = e_ctl; e.mret = e_mret; e.st = e_st; e.stall = e_stall;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [7:0] e_ctl, input logic e_mret, input logic [1:0] e_st,
                        input logic [31:0] e_stall);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
             e_ctl, e_mret, e_st, e_stall);
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                step_no++;
                act = {pc_clk_en, if_id_clk_en, if_id_flush, id_ex_clk_en, id_ex_flush,
                       ex_mem_clk_en, ex_mem_flush, trap_redirect};
                total++;
                if ({act, trap_is_mret} !== {e.ctl, e.mret}) begin
                    bad++;
                    $display("FAIL ctl step %0d: got ctl=%b mret=%b want ctl=%b mret=%b",
                             step_no, act, trap_is_mret, e.ctl, e.mret);
                end
                total++;
                if (state !== e.st) begin
                    bad++;
                    $display("FAIL state step %0d: got %0d want %0d", step_no, state, e.st);
                end
                total++;
                if (stall_cycles !== e.stall) begin
                    bad++;
                    $display("FAIL stall_cycles step %0d: got %h want %h",
                             step_no, stall_cycles, e.stall);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        // Reset state, then idle.
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b0, 2'd0, 32'd0);
        idle(NRM, 1'b0, 2'd0, 32'd0);

        // Load-use on rs2, then rd=x0, non-writing and non-load producers, then rs1 match.
        step(1'b0, 5'd0, 5'd5, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, LU,  1'b0, 2'd0, 32'd0);
        idle(NRM, 1'b0, 2'd0, 32'd1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b0, 2'd0, 32'd1);
        step(1'b0, 5'd7, 5'd0, 5'd7, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b0, 2'd0, 32'd1);
        step(1'b0, 5'd7, 5'd0, 5'd7, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b0, 2'd0, 32'd1);
        step(1'b0, 5'd9, 5'd3, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, LU,  1'b0, 2'd0, 32'd1);

        // Branch beats load-use.
        step(1'b0, 5'd9, 5'd3, 5'd9, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, BR,  1'b0, 2'd0, 32'd2);
        idle(NRM, 1'b0, 2'd0, 32'd2);

        // Memory wait three cycles with a branch held (and a stray exception ignored), then release.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, FRZ, 1'b0, 2'd0, 32'd2);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, FRZ, 1'b0, 2'd1, 32'd3);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, FRZ, 1'b0, 2'd1, 32'd4);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, BR,  1'b0, 2'd1, 32'd5);
        idle(NRM, 1'b0, 2'd0, 32'd5);

        // Exception and mret together: exception wins; busy during drain is ignored.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, TRP, 1'b0, 2'd0, 32'd5);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, TRP, 1'b0, 2'd2, 32'd6);
        idle(TRP, 1'b0, 2'd2, 32'd7);
        idle(RDR, 1'b0, 2'd3, 32'd8);
        idle(NRM, 1'b0, 2'd0, 32'd8);

        // mret alone: redirect qualified as mret.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, TRP, 1'b0, 2'd0, 32'd8);
        idle(TRP, 1'b1, 2'd2, 32'd9);
        idle(TRP, 1'b1, 2'd2, 32'd10);
        idle(RDR, 1'b1, 2'd3, 32'd11);
        idle(NRM, 1'b1, 2'd0, 32'd11);

        // Reset in the middle of a drain: no redirect, counter cleared.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, TRP, 1'b1, 2'd0, 32'd11);
        idle(TRP, 1'b0, 2'd2, 32'd12);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b0, 2'd2, 32'd13);
        idle(NRM, 1'b0, 2'd0, 32'd0);
        idle(NRM, 1'b0, 2'd0, 32'd0);

        // Saturation: preload the counter near the top, then stall three cycles.
        @(negedge clk);
        #1;
        force dut.u_stall_cnt.count_q = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.u_stall_cnt.count_q;
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, FRZ, 1'b0, 2'd0, 32'hFFFF_FFFE);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, FRZ, 1'b0, 2'd1, 32'hFFFF_FFFF);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, FRZ, 1'b0, 2'd1, 32'hFFFF_FFFF);
        idle(NRM, 1'b0, 2'd1, 32'hFFFF_FFFF);
        idle(NRM, 1'b0, 2'd0, 32'hFFFF_FFFF);

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
